// File: rtl/tempo_ctrl_if.sv
// Button inputs and tempo/BCD outputs of tempo_ctrl, grouped as one bus.
// The slave modport is the tempo_ctrl side; the master modport drives the buttons.
interface tempo_ctrl_if #(
  parameter int W      = 8,
  parameter int DIGITS = 3
);
  logic                  inc;
  logic                  dec;
  logic                  add;
  logic                  min;
  logic [W-1:0]          speed;
  logic                  changed;
  logic                  at_min;
  logic                  at_max;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;

  modport master (
    output inc, dec, add, min,
    input  speed, changed, at_min, at_max, bcd, bcd_valid
  );

  modport slave (
    input  inc, dec, add, min,
    output speed, changed, at_min, at_max, bcd, bcd_valid
  );
endinterface

// File: rtl/tempo_ctrl.sv
// Saturating BPM register driven by four button levels, plus a sequential double-dabble
// BCD converter. Define TEMPO_AUTOREPEAT_EN to build the hold-to-repeat counter.
module tempo_ctrl #(
  parameter int W        = 8,
  parameter int DIGITS   = 3,
  parameter int BPM_MIN  = 30,
  parameter int BPM_MAX  = 250,
  parameter int BPM_RST  = 120,
  parameter int FINE     = 1,
  parameter int COARSE   = 10,
  parameter int REP_DLY  = 25_000_000,
  parameter int REP_RATE = 5_000_000
) (
  input  logic          clk,
  input  logic          rst_n,   // active-high asynchronous reset
  tempo_ctrl_if.slave   bus
);

  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = $clog2(W + 1);
  localparam logic [W:0] MIN_X    = (W+1)'(BPM_MIN);
  localparam logic [W:0] MAX_X    = (W+1)'(BPM_MAX);
  localparam logic [W:0] FINE_X   = (W+1)'(FINE);
  localparam logic [W:0] COARSE_X = (W+1)'(COARSE);

  typedef enum logic [2:0] {OWN_NONE, OWN_ADD, OWN_MIN, OWN_INC, OWN_DEC} owner_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} conv_e;

  logic [3:0]   btn, btn_q, press;
  owner_e       owner_q, owner_d;
  logic         owner_held, step_en, step_up, rep_fire, update;
  logic [W:0]   amt_x, cur_x, sum_x, next_x;
  logic [W-1:0] speed_q;
  logic         changed_q;

  assign btn   = {bus.add, bus.min, bus.inc, bus.dec};
  assign press = btn & ~btn_q;
  assign cur_x = {1'b0, speed_q};

  always_comb begin
    unique case (owner_q)
      OWN_ADD: owner_held = btn[3];
      OWN_MIN: owner_held = btn[2];
      OWN_INC: owner_held = btn[1];
      OWN_DEC: owner_held = btn[0];
      default: owner_held = 1'b0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    owner_d = owner_q;
    step_en = 1'b0;
    if (!owner_held) begin
      owner_d = OWN_NONE;
      if      (press[3]) owner_d = OWN_ADD;
      else if (press[2]) owner_d = OWN_MIN;
      else if (press[1]) owner_d = OWN_INC;
      else if (press[0]) owner_d = OWN_DEC;
      step_en = |press;
    end else begin
      step_en = rep_fire;
    end
    step_up = (owner_d == OWN_ADD) || (owner_d == OWN_INC);
    amt_x   = ((owner_d == OWN_ADD) || (owner_d == OWN_MIN)) ? COARSE_X : FINE_X;
  end

  // Decrement is guarded before subtracting so it can never wrap below zero.
  always_comb begin
    sum_x = cur_x + amt_x;
    if (step_up) next_x = (sum_x > MAX_X) ? MAX_X : sum_x;
    else         next_x = (cur_x < amt_x + MIN_X) ? MIN_X : cur_x - amt_x;
    update = step_en && (next_x != cur_x);
  end

`ifdef TEMPO_AUTOREPEAT_EN
  localparam int RMAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
  localparam int CW   = $clog2(RMAX + 1);

  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;

  always_comb begin
    rep_cnt_d   = rep_cnt_q + 1'b1;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (!owner_held) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_cnt_d == CW'(rep_first_q ? REP_DLY : REP_RATE)) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  // No repeat hardware; the timing parameters are only referenced to keep one interface.
  assign rep_fire = 1'b0 & (REP_DLY > 0) & (REP_RATE > 0);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      speed_q   <= W'(BPM_RST);
      changed_q <= 1'b0;
      btn_q     <= '0;
      owner_q   <= OWN_NONE;
    end else begin
      btn_q     <= btn;
      owner_q   <= owner_d;
      changed_q <= update;
      if (update) speed_q <= next_x[W-1:0];
    end
  end

  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++)
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    return r;
  endfunction

  conv_e         state_q;
  logic [W-1:0]  sh_q;
  logic [BW-1:0] scr_q, bcd_q;
  logic [CNTW-1:0] bit_q;
  logic          valid_q;

  // IDLE loads on the same edge it sees changed so bcd_valid drops two edges after the press.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_LOAD;
      sh_q    <= '0;
      scr_q   <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_LOAD: begin
          if (state_q == S_LOAD || changed_q) begin
            sh_q    <= speed_q;
            scr_q   <= '0;
            bit_q   <= '0;
            valid_q <= 1'b0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (changed_q) begin
            state_q <= S_LOAD;
          end else begin
            {scr_q, sh_q} <= {dd_adjust(scr_q), sh_q} << 1;
            bit_q         <= bit_q + 1'b1;
            if (bit_q == CNTW'(W - 1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (changed_q) begin
            state_q <= S_LOAD;
          end else begin
            bcd_q   <= scr_q;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.speed     = speed_q;
  assign bus.changed   = changed_q;
  assign bus.at_min    = (speed_q == W'(BPM_MIN));
  assign bus.at_max    = (speed_q == W'(BPM_MAX));
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = valid_q;

endmodule

// File: doc/tempo_ctrl.md
# tempo_ctrl

Parametrised tempo register for the metronome datapath, replacing the fixed 8-bit speed logic and the combinational divide/modulo BCD split. It takes the four debounced button levels, applies fine and coarse steps with saturation and optional hold-to-repeat, and holds the current BPM. A sequential double-dabble converter turns that BPM into packed BCD for the seven-segment driver.

## Interface
- `W`, 8: BPM register width.
- `DIGITS`, 3: BCD digits produced. Must satisfy 10^DIGITS > 2^W − 1.
- `BPM_MIN`, 30: lower clamp.
- `BPM_MAX`, 250: upper clamp. Must be < 2^W.
- `BPM_RST`, 120: value loaded at reset.
- `FINE`, 1: step applied by `inc`/`dec`.
- `COARSE`, 10: step applied by `add`/`min`.
- `REP_DLY`, 25_000_000: held cycles before auto-repeat starts.
- `REP_RATE`, 5_000_000: cycles between repeat steps.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-high reset. The codebase port name is kept; asserted = 1.
- `inc`  in  1  debounced level, fine increment.
- `dec`  in  1  debounced level, fine decrement.
- `add`  in  1  debounced level, coarse increment.
- `min`  in  1  debounced level, coarse decrement.
- `speed`  out  W  current BPM.
- `changed`  out  1  one-cycle pulse whenever `speed` takes a new value.
- `at_min`  out  1  `speed == BPM_MIN`.
- `at_max`  out  1  `speed == BPM_MAX`.
- `bcd`  out  4*DIGITS  packed BCD of `speed`, with the units digit in [3:0].
- `bcd_valid`  out  1  `bcd` matches the current `speed`.

## Operation
- **Reset values:** `speed = BPM_RST`, `bcd = 0`, `bcd_valid = 0`, `changed = 0`. The converter FSM resets to LOAD.
- **Edge detect:** each button is registered once. A press is the current level high while the registered level is low.
- **Arbitration on a press:** if several presses occur in the same cycle, one step is taken in priority order `add` > `min` > `inc` > `dec`.
- **Held button:** the button owning the repeat counter stays active until it is released. Presses of other buttons while it is held are ignored.
- **Step arithmetic:** computed at W+1 bits, then saturated to [BPM_MIN, BPM_MAX].
  - If the result equals the current `speed` (already at the limit), `speed` is unchanged and `changed` stays 0.
- **Auto-repeat** (only when the macro below is defined):
  - After a step, a counter runs while the owning button remains high.
  - The first repeat step fires REP_DLY cycles after the press step.
  - Each further repeat step fires every REP_RATE cycles.
  - Releasing the button clears the counter.
- **Converter FSM:**
  - IDLE: wait for `changed`.
  - LOAD: latch `speed` into the shift register, clear the BCD scratch register, drop `bcd_valid`.
  - SHIFT: W iterations. Each iteration adds 3 to any scratch digit ≥ 5, then shifts left one bit.
  - DONE: copy the scratch register to `bcd`, set `bcd_valid`, return to IDLE.
- **Conversion restart:** a `changed` pulse in SHIFT or DONE forces LOAD on the next cycle. `bcd` keeps its old value until a conversion completes.
- **Reset mid-operation:** all state returns to its reset value immediately (asynchronous reset).

## Timing
- **Press to `speed`:** a press sampled at clock edge N updates `speed` and pulses `changed` on edge N+1.
- **`speed` to `bcd`:** `bcd_valid` falls on edge N+2 (LOAD). `bcd` updates and `bcd_valid` rises on edge N+W+3.
- **After reset release:** the first conversion of BPM_RST completes with `bcd_valid = 1` W+2 cycles after the first clock edge.
- **Flag timing:** `at_min` and `at_max` are combinational from `speed`.
- **Fastest step rate:** one step per cycle, when REP_RATE = 1. Every step restarts the conversion, so `bcd_valid` stays low until steps stop.

## Configuration
- `TEMPO_AUTOREPEAT_EN` defined: hold-to-repeat as described; the repeat counter is instantiated.
- `TEMPO_AUTOREPEAT_EN` undefined: exactly one step per press regardless of hold time; no repeat counter exists, and REP_DLY/REP_RATE are unused.

## Test plan
Defaults apply except REP_DLY = 8 and REP_RATE = 4.
- **Reset:** release reset → `speed = 120`, and `bcd = 12'h120` with `bcd_valid = 1` after 10 cycles.
- **Single presses:** one-cycle `inc` pulse → `speed = 121`, `changed` high for 1 cycle, `bcd = 12'h121` 11 cycles after the press. Then one `min` pulse → `speed = 111`.
- **Saturation:** from 245, `add` pulse → `speed = 250`, `at_max = 1`. A second `add` → no change and no `changed`. From 35, two `min` pulses → `speed = 30`, then unchanged.
- **Auto-repeat:** hold `inc` for 20 cycles from 100 → steps at the press, +8, +12, +16, +20, ending at `speed = 105`. With the macro undefined → `speed = 101`.
- **Simultaneous presses:** `add` and `dec` rise in the same cycle from 100 → `speed = 110` only.
- **Restart and reset mid-conversion:**
  - An `inc` press at cycle 4 of a conversion → `bcd` updates only once, to the final value, with no intermediate value visible.
  - Asserting `rst_n` mid-SHIFT → `speed = 120`, `bcd_valid = 0` immediately.
